instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 16 +
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width and the fetch-unit state encoding.
package cpu_pkg;

  // Width of one instruction word.
  localparam int INSTR_W = 10;

  // States of the instruction fetch sequencer.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_EXEC = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer.
// Owns the program counter. For each instruction it issues a one-cycle read
// strobe, waits for the memory response (re-issuing the read on timeout),
// presents the word to the instruction register with a one-cycle load strobe,
// then waits for the core to finish executing it before fetching the next one.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic [INSTR_W-1:0] instr_IRload,
  output logic               IRload,
  input  logic               exec_done,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_err
);

  // The counter must be able to hold TIMEOUT-1, the value at which the
  // final silent WAIT cycle is recognised.
  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic               err_reg, err_next;

  // State register; reset returns to IDLE from anywhere, dropping any
  // response that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: program counter, timeout counter, fetched word and
  // the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      cnt_reg   <= '0;
      instr_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      instr_reg <= instr_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath update logic; every value holds unless a state
  // below says otherwise.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    instr_next = instr_reg;
    err_next   = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          // Only a response seen in WAIT reaches the instruction register.
          instr_next = mem_rdata;
          cnt_next   = '0;
          state_next = S_LOAD;
        end else if (cnt_reg == CNT_LAST) begin
          // This is the TIMEOUT-th silent cycle: flag it and retry the
          // same address.
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = S_REQ;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_LOAD: begin
        // Natural wrap from the top address back to zero.
        pc_next    = pc_reg + ADDR_W'(1);
        state_next = S_EXEC;
      end

      S_EXEC: begin
        if (exec_done) begin
          // A taken branch replaces the increment done in LOAD; it is
          // applied even when halting so the next start fetches the target.
          if (pc_load) begin
            pc_next = pc_target;
          end
          state_next = halt ? S_IDLE : S_REQ;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state and registers only, never from inputs.
  assign mem_req      = (state_reg == S_REQ);
  assign mem_addr     = ((state_reg == S_REQ) || (state_reg == S_WAIT)) ? pc_reg : '0;
  assign IRload       = (state_reg == S_LOAD);
  assign busy         = (state_reg != S_IDLE);
  assign instr_IRload = instr_reg;
  assign fetch_err    = err_reg;
  assign pc           = pc_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch.
module tb_instr_fetch;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [9:0]        mem_rdata;
  logic              mem_rvalid;
  logic [9:0]        instr_IRload;
  logic              IRload;
  logic              exec_done;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_err;

  int n_cmp = 0;
  int n_mis = 0;
  int ir_pulses = 0;
  logic [ADDR_W-1:0] req_addrs[$];

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(8'h00),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr_IRload(instr_IRload),
    .IRload      (IRload),
    .exec_done   (exec_done),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .halt        (halt),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe strobes mid-cycle: count IRload pulses and log every read address.
  always @(negedge clk) begin
    if (IRload === 1'b1) ir_pulses++;
    if (mem_req === 1'b1) req_addrs.push_back(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // From REQ: answer two cycles after the strobe, finish in EXEC.
  task automatic do_fetch(input logic [9:0] data);
    tick();            // WAIT
    tick();            // WAIT, second cycle
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();            // LOAD
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();            // EXEC
  endtask

  task automatic exec_step(input logic ld, input logic [ADDR_W-1:0] tgt, input logic hlt);
    exec_done = 1'b1;
    pc_load   = ld;
    pc_target = tgt;
    halt      = hlt;
    tick();
    exec_done = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    halt      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc !== 8'h00) begin n_mis++; $display("FAIL reset_pc: got %h expected 00", pc); end
    n_cmp++; if (mem_req !== 1'b0) begin n_mis++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_mis++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_mis++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
    n_cmp++; if (IRload !== 1'b0) begin n_mis++; $display("FAIL reset_IRload: got %b expected 0", IRload); end
    n_cmp++; if (instr_IRload !== 10'h000) begin n_mis++; $display("FAIL reset_instr: got %h expected 000", instr_IRload); end
    // Start is the only way out of IDLE; other inputs are ignored there.
    mem_rvalid = 1'b1; mem_rdata = 10'h3C3; exec_done = 1'b1; pc_load = 1'b1; pc_target = 8'h77;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; exec_done = 1'b0; pc_load = 1'b0; pc_target = '0;
    n_cmp++; if ({busy, pc, instr_IRload} !== {1'b0, 8'h00, 10'h000}) begin n_mis++; $display("FAIL idle_ignore: got busy=%b pc=%h instr=%h expected 0/00/000", busy, pc, instr_IRload); end
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    int ir0;
    ir0 = ir_pulses;
    start = 1'b1;
    tick();            // REQ
    start = 1'b0;
    n_cmp++; if ({mem_req, mem_addr, busy} !== {1'b1, 8'h00, 1'b1}) begin n_mis++; $display("FAIL single_req: got req=%b addr=%h busy=%b expected 1/00/1", mem_req, mem_addr, busy); end
    tick();            // WAIT
    n_cmp++; if ({mem_req, mem_addr} !== {1'b0, 8'h00}) begin n_mis++; $display("FAIL single_wait: got req=%b addr=%h expected 0/00", mem_req, mem_addr); end
    tick();            // WAIT
    mem_rvalid = 1'b1; mem_rdata = 10'h2A5;
    tick();            // LOAD
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_cmp++; if ({IRload, instr_IRload, pc} !== {1'b1, 10'h2A5, 8'h00}) begin n_mis++; $display("FAIL single_load: got IRload=%b instr=%h pc=%h expected 1/2a5/00", IRload, instr_IRload, pc); end
    tick();            // EXEC
    n_cmp++; if ({IRload, instr_IRload, pc} !== {1'b0, 10'h2A5, 8'h01}) begin n_mis++; $display("FAIL single_exec: got IRload=%b instr=%h pc=%h expected 0/2a5/01", IRload, instr_IRload, pc); end
    n_cmp++; if (ir_pulses - ir0 !== 1) begin n_mis++; $display("FAIL single_pulses: got %0d expected 1", ir_pulses - ir0); end
    // EXEC holds until exec_done.
    tick(); tick();
    n_cmp++; if ({busy, mem_req, IRload} !== 3'b100) begin n_mis++; $display("FAIL exec_hold: got busy=%b req=%b IRload=%b expected 1/0/0", busy, mem_req, IRload); end
    exec_step(1'b0, 8'h00, 1'b1);
    n_cmp++; if ({busy, pc} !== {1'b0, 8'h01}) begin n_mis++; $display("FAIL single_halt: got busy=%b pc=%h expected 0/01", busy, pc); end
    $display("test_single_fetch done");
  endtask

  task automatic test_three_fetch();
    int ir0;
    do_reset();
    req_addrs.delete();
    ir0 = ir_pulses;
    start = 1'b1; tick(); start = 1'b0;
    do_fetch(10'h101);
    exec_step(1'b0, 8'h00, 1'b0);
    do_fetch(10'h102);
    exec_step(1'b0, 8'h00, 1'b0);
    do_fetch(10'h103);
    n_cmp++; if (pc !== 8'h03) begin n_mis++; $display("FAIL three_pc: got %h expected 03", pc); end
    n_cmp++; if (instr_IRload !== 10'h103) begin n_mis++; $display("FAIL three_instr: got %h expected 103", instr_IRload); end
    n_cmp++; if (ir_pulses - ir0 !== 3) begin n_mis++; $display("FAIL three_pulses: got %0d expected 3", ir_pulses - ir0); end
    n_cmp++; if (req_addrs.size() !== 3) begin n_mis++; $display("FAIL three_req_count: got %0d expected 3", req_addrs.size()); end
    for (int i = 0; i < 3 && i < req_addrs.size(); i++) begin
      n_cmp++; if (req_addrs[i] !== 8'(i)) begin n_mis++; $display("FAIL three_addr%0d: got %h expected %h", i, req_addrs[i], 8'(i)); end
    end
    exec_step(1'b0, 8'h00, 1'b1);
    $display("test_three_fetch done");
  endtask

  task automatic test_branch();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (mem_addr !== 8'h03) begin n_mis++; $display("FAIL branch_first_addr: got %h expected 03", mem_addr); end
    do_fetch(10'h1F0);
    n_cmp++; if (pc !== 8'h04) begin n_mis++; $display("FAIL branch_pre_pc: got %h expected 04", pc); end
    exec_step(1'b1, 8'h40, 1'b0);   // REQ at branch target
    n_cmp++; if ({mem_req, mem_addr, pc} !== {1'b1, 8'h40, 8'h40}) begin n_mis++; $display("FAIL branch_target: got req=%b addr=%h pc=%h expected 1/40/40", mem_req, mem_addr, pc); end
    do_fetch(10'h0AA);
    // Branch together with halt: target taken, then IDLE.
    exec_step(1'b1, 8'h80, 1'b1);
    n_cmp++; if ({busy, pc} !== {1'b0, 8'h80}) begin n_mis++; $display("FAIL branch_halt: got busy=%b pc=%h expected 0/80", busy, pc); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h80}) begin n_mis++; $display("FAIL branch_halt_restart: got req=%b addr=%h expected 1/80", mem_req, mem_addr); end
    do_fetch(10'h011);
    exec_step(1'b0, 8'h00, 1'b1);
    $display("test_branch done");
  endtask

  task automatic test_timeout();
    int ir0;
    do_reset();
    ir0 = ir_pulses;
    start = 1'b1; tick(); start = 1'b0;   // REQ
    tick();                               // WAIT, first silent cycle
    for (int i = 0; i < 14; i++) tick();  // fifteenth silent WAIT cycle
    n_cmp++; if ({mem_req, fetch_err, mem_addr} !== {1'b0, 1'b0, 8'h00}) begin n_mis++; $display("FAIL timeout_edge: got req=%b err=%b addr=%h expected 0/0/00", mem_req, fetch_err, mem_addr); end
    tick();                               // re-issued REQ
    n_cmp++; if ({mem_req, fetch_err, mem_addr} !== {1'b1, 1'b1, 8'h00}) begin n_mis++; $display("FAIL timeout_retry: got req=%b err=%b addr=%h expected 1/1/00", mem_req, fetch_err, mem_addr); end
    do_fetch(10'h155);
    n_cmp++; if ({pc, instr_IRload, fetch_err} !== {8'h01, 10'h155, 1'b1}) begin n_mis++; $display("FAIL timeout_complete: got pc=%h instr=%h err=%b expected 01/155/1", pc, instr_IRload, fetch_err); end
    n_cmp++; if (ir_pulses - ir0 !== 1) begin n_mis++; $display("FAIL timeout_pulses: got %0d expected 1", ir_pulses - ir0); end
    // A response outside WAIT must not disturb the instruction register.
    mem_rvalid = 1'b1; mem_rdata = 10'h0F0;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_cmp++; if ({instr_IRload, IRload} !== {10'h155, 1'b0}) begin n_mis++; $display("FAIL stray_rvalid: got instr=%h IRload=%b expected 155/0", instr_IRload, IRload); end
    exec_step(1'b0, 8'h00, 1'b1);
    n_cmp++; if ({busy, fetch_err} !== 2'b01) begin n_mis++; $display("FAIL err_sticky: got busy=%b err=%b expected 0/1", busy, fetch_err); end
    $display("test_timeout done");
  endtask

  task automatic test_wrap_halt();
    do_reset();
    n_cmp++; if (fetch_err !== 1'b0) begin n_mis++; $display("FAIL err_cleared: got %b expected 0", fetch_err); end
    start = 1'b1; tick(); start = 1'b0;
    do_fetch(10'h001);
    exec_step(1'b1, 8'hFF, 1'b0);
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'hFF}) begin n_mis++; $display("FAIL wrap_req: got req=%b addr=%h expected 1/ff", mem_req, mem_addr); end
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 10'h3FF;
    tick();            // LOAD
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_cmp++; if ({IRload, pc} !== {1'b1, 8'hFF}) begin n_mis++; $display("FAIL wrap_load: got IRload=%b pc=%h expected 1/ff", IRload, pc); end
    tick();            // EXEC
    n_cmp++; if ({pc, fetch_err} !== {8'h00, 1'b0}) begin n_mis++; $display("FAIL wrap_pc: got pc=%h err=%b expected 00/0", pc, fetch_err); end
    exec_step(1'b0, 8'h00, 1'b1);
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_mis++; $display("FAIL wrap_halt: got busy=%b req=%b expected 0/0", busy, mem_req); end
    $display("test_wrap_halt done");
  endtask

  task automatic test_reset_mid_wait();
    int ir0;
    start = 1'b1; tick(); start = 1'b0;
    do_fetch(10'h222);
    exec_step(1'b1, 8'h22, 1'b0);   // REQ at 0x22
    tick(); tick();                  // WAIT
    n_cmp++; if ({busy, mem_addr} !== {1'b1, 8'h22}) begin n_mis++; $display("FAIL midwait_pre: got busy=%b addr=%h expected 1/22", busy, mem_addr); end
    ir0 = ir_pulses;
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({busy, pc, mem_addr} !== {1'b0, 8'h00, 8'h00}) begin n_mis++; $display("FAIL midwait_reset: got busy=%b pc=%h addr=%h expected 0/00/00", busy, pc, mem_addr); end
    // The late response must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 10'h1E1;
    tick(); tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_cmp++; if ({IRload, instr_IRload, busy} !== {1'b0, 10'h000, 1'b0}) begin n_mis++; $display("FAIL midwait_late: got IRload=%b instr=%h busy=%b expected 0/000/0", IRload, instr_IRload, busy); end
    n_cmp++; if (ir_pulses - ir0 !== 0) begin n_mis++; $display("FAIL midwait_pulses: got %0d expected 0", ir_pulses - ir0); end
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    exec_done  = 1'b0;
    pc_load    = 1'b0;
    pc_target  = '0;
    halt       = 1'b0;
    test_reset();
    test_single_fetch();
    test_three_fetch();
    test_branch();
    test_timeout();
    test_wrap_halt();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
